mem_wb_stage: RTL

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage_pkg.sv | 30 +++
 rtl/memwb_reg.sv | 72 +++++++
 rtl/mem_wb_stage.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage_pkg
//  Description : Shared definitions for the MEM stage and MEM/WB register.
//                Holds the control-word bit positions, FSM state encodings
//                and the default memory-ack timeout.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_wb_stage_pkg;

    // Bit positions inside the 7-bit control word from EX/MEM
    localparam int unsigned CTRL_REGWRITE = 6;
    localparam int unsigned CTRL_MEMTOREG = 5;
    localparam int unsigned CTRL_BRANCH   = 4;
    localparam int unsigned CTRL_MEMREAD  = 3;
    localparam int unsigned CTRL_MEMWRITE = 2;
    localparam int unsigned CTRL_JUMP     = 1;
    localparam int unsigned CTRL_BRANCHNE = 0;

    // Cycles to wait for an acknowledge before abandoning an access
    localparam int unsigned TMO_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

endpackage : mem_wb_stage_pkg
`default_nettype wire

// File: rtl/memwb_reg.sv
`default_nettype none
// ============================================================================
//  Module      : memwb_reg
//  Description : MEM/WB pipeline register. Loads on every edge while load_i
//                is high. A bubble clears the two write-back control bits
//                and keeps every data field as it was.
//  Ports       : clk_i, rst_i (async, active-high)
//                load_i, bubble_i          - load enable / bubble insert
//                regwrite_i, memtoreg_i    - control bits to register
//                rdata_i, retalu_i,
//                wbdata_i, wbaddr_i        - data fields to register
//                *_o                       - registered copies
//  Revision    : 1.0  initial release
// ============================================================================
module memwb_reg (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic        regwrite_i,
    input  logic        memtoreg_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] retalu_i,
    input  logic [31:0] wbdata_i,
    input  logic [4:0]  wbaddr_i,
    output logic        regwrite_o,
    output logic        memtoreg_o,
    output logic [31:0] rdata_o,
    output logic [31:0] retalu_o,
    output logic [31:0] wbdata_o,
    output logic [4:0]  wbaddr_o
);

    logic        regwrite_q;
    logic        memtoreg_q;
    logic [31:0] rdata_q;
    logic [31:0] retalu_q;
    logic [31:0] wbdata_q;
    logic [4:0]  wbaddr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            rdata_q    <= 32'd0;
            retalu_q   <= 32'd0;
            wbdata_q   <= 32'd0;
            wbaddr_q   <= 5'd0;
        end else if (load_i) begin
            if (bubble_i) begin
                regwrite_q <= 1'b0;
                memtoreg_q <= 1'b0;
            end else begin
                regwrite_q <= regwrite_i;
                memtoreg_q <= memtoreg_i;
                rdata_q    <= rdata_i;
                retalu_q   <= retalu_i;
                wbdata_q   <= wbdata_i;
                wbaddr_q   <= wbaddr_i;
            end
        end
    end

    assign regwrite_o = regwrite_q;
    assign memtoreg_o = memtoreg_q;
    assign rdata_o    = rdata_q;
    assign retalu_o   = retalu_q;
    assign wbdata_o   = wbdata_q;
    assign wbaddr_o   = wbaddr_q;

endmodule : memwb_reg
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage
//  Description : MEM pipeline stage. Issues data-memory requests, stalls the
//                front of the pipe until the memory acknowledges, abandons an
//                access after TMO cycles (sticky error flag), resolves
//                branches/jumps and feeds the MEM/WB register.
//  Ports       : clk_i, rst_i (async, active-high)
//                ctrl_signal_i, pc_branch_i, pc_jump_i, zero_i, retAlu_i,
//                Wridata_i, WBaddr_i              - from EX/MEM
//                dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o,
//                dm_ack_i, dm_rdata_i             - data-memory handshake
//                stall_o, pc_src_o, pc_target_o, flush_o - hazard / redirect
//                RegWrite_o, MemtoReg_o, rdata_o, retAlu_o, wbdata_o,
//                WBaddr_o                         - MEM/WB register
//                mem_err_o                        - sticky timeout flag
//  Revision    : 1.0  initial release
// ============================================================================
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned TMO = TMO_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [6:0]  ctrl_signal_i,
    input  logic [31:0] pc_branch_i,
    input  logic [31:0] pc_jump_i,
    input  logic        zero_i,
    input  logic [31:0] retAlu_i,
    input  logic [31:0] Wridata_i,
    input  logic [4:0]  WBaddr_i,
    output logic        dm_req_o,
    output logic        dm_we_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_wdata_o,
    input  logic        dm_ack_i,
    input  logic [31:0] dm_rdata_i,
    output logic        stall_o,
    output logic        pc_src_o,
    output logic [31:0] pc_target_o,
    output logic        flush_o,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [31:0] rdata_o,
    output logic [31:0] retAlu_o,
    output logic [31:0] wbdata_o,
    output logic [4:0]  WBaddr_o,
    output logic        mem_err_o
);

    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic        mem_op;
    logic        req;
    logic        stall;
    logic        rd_done;
    logic [31:0] rd_data;
    logic [31:0] wb_data;
    logic        bubble;
    logic        taken;

    // ------------------------------------------------------------------
    // Memory request / stall. Reset masks the request combinationally so
    // an in-flight access is dropped without waiting for an edge.
    // ------------------------------------------------------------------
    always_comb begin
        mem_op  = ctrl_signal_i[CTRL_MEMREAD] | ctrl_signal_i[CTRL_MEMWRITE];
        req     = mem_op & (state_q != ST_ERR) & ~rst_i;
        stall   = req & ~dm_ack_i;
        // A combined read+write control word is treated as a store
        rd_done = req & dm_ack_i & ~ctrl_signal_i[CTRL_MEMWRITE];
        rd_data = rd_done ? dm_rdata_i : 32'd0;
        wb_data = ctrl_signal_i[CTRL_MEMTOREG] ? rd_data : retAlu_i;
        bubble  = stall | (state_q == ST_ERR);
        taken   = (ctrl_signal_i[CTRL_BRANCH] &
                   (zero_i ^ ctrl_signal_i[CTRL_BRANCHNE])) |
                  ctrl_signal_i[CTRL_JUMP];
    end

    assign dm_req_o    = req;
    assign dm_we_o     = req & ctrl_signal_i[CTRL_MEMWRITE];
    assign dm_addr_o   = req ? retAlu_i  : 32'd0;
    assign dm_wdata_o  = req ? Wridata_i : 32'd0;
    assign stall_o     = stall;
    assign pc_src_o    = taken & ~stall & ~rst_i;
    assign flush_o     = taken & ~stall & ~rst_i;
    assign pc_target_o = rst_i ? 32'd0 :
                         (ctrl_signal_i[CTRL_JUMP] ? pc_jump_i : pc_branch_i);
    assign mem_err_o   = err_q;

    // ------------------------------------------------------------------
    // FSM next state, wait counter and sticky error flag
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (mem_op && !dm_ack_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // An ack on the last allowed cycle still completes the access
                if (dm_ack_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = ST_ERR;
                    cnt_d   = 8'd0;
                    err_d   = 1'b1;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    memwb_reg u_memwb_reg (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (1'b1),
        .bubble_i   (bubble),
        .regwrite_i (ctrl_signal_i[CTRL_REGWRITE]),
        .memtoreg_i (ctrl_signal_i[CTRL_MEMTOREG]),
        .rdata_i    (rd_data),
        .retalu_i   (retAlu_i),
        .wbdata_i   (wb_data),
        .wbaddr_i   (WBaddr_i),
        .regwrite_o (RegWrite_o),
        .memtoreg_o (MemtoReg_o),
        .rdata_o    (rdata_o),
        .retalu_o   (retAlu_o),
        .wbdata_o   (wbdata_o),
        .wbaddr_o   (WBaddr_o)
    );

endmodule : mem_wb_stage
`default_nettype wire
